mem_arbiter: RTL and testbench

- Two-port arbiter sharing the single-word 16-bit program/data memory between the stack CPU (port 0) and the loader/debug requester (port 1).
- Issues at most one memory access per cycle.
- Applies burst-limited round-robin ownership with a tie-break preference.
- Routes the one-cycle-latency read data back to the requester that issued the read.
- Sits between the CPU address/data pins and the synchronous memory macro.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the synchronous memory macro.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port burst-limited round-robin arbiter in front of a single-port synchronous memory.
// One access per cycle; read data is steered back to the port that issued the read.
module mem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int BURST_MAX = 4,
    parameter int PRIO      = 0
) (
    input  logic       clk,
    input  logic       rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       rd_pend, rd_tag;
    logic       gnt_any, gnt_sel;
    logic       sel_we;
    logic       owner_match;

    // Grant choice; gated by rst so every output is quiet while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (!rst) begin
            if (bus.req0 && bus.req1) begin
                gnt_any = 1'b1;
                case (state)
                    OWN0:    gnt_sel = (burst_cnt < BMAX) ? 1'b0 : 1'b1;
                    OWN1:    gnt_sel = (burst_cnt < BMAX) ? 1'b1 : 1'b0;
                    default: gnt_sel = (PRIO == 1);
                endcase
            end else if (bus.req0) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (bus.req1) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = IDLE;
        burst_nxt   = 4'd0;
        owner_match = gnt_sel ? (state == OWN1) : (state == OWN0);
        if (gnt_any) begin
            state_nxt = gnt_sel ? OWN1 : OWN0;
            if (!owner_match)
                burst_nxt = 4'd1;
            else if (burst_cnt >= BMAX)
                burst_nxt = BMAX;
            else
                burst_nxt = burst_cnt + 4'd1;
        end
    end

    assign sel_we        = gnt_sel ? bus.we1 : bus.we0;
    assign bus.gnt0      = gnt_any & ~gnt_sel;
    assign bus.gnt1      = gnt_any & gnt_sel;
    assign bus.mem_en    = gnt_any;
    assign bus.mem_we    = gnt_any & sel_we;
    assign bus.mem_addr  = !gnt_any ? '0 : (gnt_sel ? bus.addr1 : bus.addr0);
    assign bus.mem_wdata = !gnt_any ? '0 : (gnt_sel ? bus.wdata1 : bus.wdata0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Memory answers one cycle after the strobe, so remember who asked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            rd_pend <= gnt_any & ~sel_we;
            if (gnt_any && !sel_we)
                rd_tag <= gnt_sel;
        end
    end

    assign bus.rvalid0 = rd_pend & ~rd_tag;
    assign bus.rvalid1 = rd_pend & rd_tag;
    assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
    assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small write-first synchronous memory model.
module tb_mem_arbiter;

    localparam logic [31:0] S_IDLE = 32'd0;
    localparam logic [31:0] S_OWN0 = 32'd1;
    localparam logic [31:0] S_OWN1 = 32'd2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem [0:255] = '{1: 16'h1111, 2: 16'h2222, default: 16'h0000};
    logic [15:0] rdq = 16'h0000;
    int          pat [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.AW(16), .DW(16), .BURST_MAX(4), .PRIO(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Write-first memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
                rdq <= bus.mem_wdata;
            end else begin
                rdq <= mem[bus.mem_addr[7:0]];
            end
        end
    end
    assign bus.mem_rdata = rdq;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                                 input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst_gnt0", 32'(bus.gnt0), 32'd0);
        checkOutput("rst_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_state", 32'(dut.state), S_IDLE);
        checkOutput("rst_burst", 32'(dut.burst_cnt), 32'd0);

        // Single port write then read-back
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        checkOutput("wr_gnt0", 32'(bus.gnt0), 32'd1);
        checkOutput("wr_mem_we", 32'(bus.mem_we), 32'd1);
        checkOutput("wr_mem_addr", 32'(bus.mem_addr), 32'h0010);
        checkOutput("wr_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        checkOutput("rd_gnt0", 32'(bus.gnt0), 32'd1);
        checkOutput("rd_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("wr_no_rvalid", 32'(bus.rvalid0), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        checkOutput("rd_rvalid0", 32'(bus.rvalid0), 32'd1);
        checkOutput("rd_rdata0", 32'(bus.rdata0), 32'hBEEF);
        checkOutput("rd_rvalid1", 32'(bus.rvalid1), 32'd0);
        checkOutput("idle_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("rd_state", 32'(dut.state), S_OWN0);
        nextCycle();
        checkOutput("idle_state", 32'(dut.state), S_IDLE);
        checkOutput("idle_burst", 32'(dut.burst_cnt), 32'd0);
        checkOutput("idle_rvalid0", 32'(bus.rvalid0), 32'd0);

        // Tie from IDLE, then continuous contention for the burst pattern
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("burst_gnt0_%0d", i), 32'(bus.gnt0), 32'(pat[i] == 0));
            checkOutput($sformatf("burst_gnt1_%0d", i), 32'(bus.gnt1), 32'(pat[i] == 1));
            if (i > 0) begin
                checkOutput($sformatf("route_rv0_%0d", i), 32'(bus.rvalid0), 32'(pat[i-1] == 0));
                checkOutput($sformatf("route_rv1_%0d", i), 32'(bus.rvalid1), 32'(pat[i-1] == 1));
                checkOutput($sformatf("route_rd0_%0d", i), 32'(bus.rdata0), (pat[i-1] == 0) ? 32'h1111 : 32'h0);
                checkOutput($sformatf("route_rd1_%0d", i), 32'(bus.rdata1), (pat[i-1] == 1) ? 32'h2222 : 32'h0);
            end
            if (i == 1)
                checkOutput("tie_state", 32'(dut.state), S_OWN0);
            nextCycle();
        end

        // Owner drops while the other port is still waiting
        checkOutput("drop_pre_state", 32'(dut.state), S_OWN0);
        checkOutput("drop_pre_burst", 32'(dut.burst_cnt), 32'd2);
        applyStimulus(1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
        #1;
        checkOutput("drop_gnt1", 32'(bus.gnt1), 32'd1);
        checkOutput("drop_gnt0", 32'(bus.gnt0), 32'd0);
        checkOutput("drop_mem_addr", 32'(bus.mem_addr), 32'h0002);
        nextCycle();
        checkOutput("drop_state", 32'(dut.state), S_OWN1);
        checkOutput("drop_burst", 32'(dut.burst_cnt), 32'd1);

        // Alternating single-port reads
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0000);
        #1;
        checkOutput("alt_gnt0", 32'(bus.gnt0), 32'd1);
        checkOutput("alt_rv1_a", 32'(bus.rvalid1), 32'd1);
        checkOutput("alt_rd1_a", 32'(bus.rdata1), 32'h2222);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
        #1;
        checkOutput("alt_gnt1", 32'(bus.gnt1), 32'd1);
        checkOutput("alt_rv0", 32'(bus.rvalid0), 32'd1);
        checkOutput("alt_rd0", 32'(bus.rdata0), 32'h1111);
        checkOutput("alt_rv1_b", 32'(bus.rvalid1), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0000);
        #1;
        checkOutput("alt_rv1_c", 32'(bus.rvalid1), 32'd1);
        checkOutput("alt_rd1_c", 32'(bus.rdata1), 32'h2222);
        checkOutput("alt_rd0_c", 32'(bus.rdata0), 32'h0);
        checkOutput("mid_gnt0", 32'(bus.gnt0), 32'd1);

        // Reset asserted mid-cycle while a read is being granted
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mrst_gnt0", 32'(bus.gnt0), 32'd0);
        checkOutput("mrst_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("mrst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("mrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("mrst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("mrst_rvalid1", 32'(bus.rvalid1), 32'd0);
        checkOutput("mrst_rvalid0", 32'(bus.rvalid0), 32'd0);
        checkOutput("mrst_state", 32'(dut.state), S_IDLE);
        nextCycle();
        checkOutput("mrst_hold_rv0", 32'(bus.rvalid0), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        nextCycle();
        checkOutput("post_rst_rv0", 32'(bus.rvalid0), 32'd0);
        checkOutput("post_rst_rv1", 32'(bus.rvalid1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
